fft_power_framer: RTL

Upstream stage of `formant`: converts the streaming complex FFT output into a power spectrum and pools adjacent bins. It keeps the lowest `I` pooled bins of each frame and replays them to `formant` as one contiguous `I`-cycle burst on `fft_valid`/`fft_data`. It also rate-limits bursts so `formant` always has at least `MIN_GAP` cycles to finish its dynamic-programming pass. Malformed or too-early frames are dropped and flagged.

---
 rtl/formant_pkg.sv | 7 +
 rtl/fft_power_framer_power_pool.sv | 56 +++++
 rtl/fft_power_framer.sv | 88 ++++++++
 3 files changed

// File: rtl/formant_pkg.sv
// formant_pkg: constants and FSM encoding shared by the framer and formant
package formant_pkg;
  localparam int BIT_WIDTH = 32;
  localparam int I = 160;
  localparam int POW_EXTRA = 1;
  typedef enum logic [1:0] {IDLE, ARM, BURST} framer_state_t;
endpackage

// File: rtl/fft_power_framer_power_pool.sv
// power_pool: squares complex FFT samples and sums adjacent bins with saturation
module power_pool #(
  parameter int IN_WIDTH = 16,
  parameter int BIT_WIDTH = 32,
  parameter int FFT_SIZE = 1024,
  parameter int I = 160,
  parameter int BINS_PER_OUT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [$clog2(FFT_SIZE)-1:0] bin,
  input  logic signed [IN_WIDTH-1:0] re,
  input  logic signed [IN_WIDTH-1:0] im,
  output logic pool_valid,
  output logic [(I > 1 ? $clog2(I) : 1)-1:0] pool_idx,
  output logic [BIT_WIDTH-1:0] pool_data
);
  import formant_pkg::*;
  localparam int AW = I > 1 ? $clog2(I) : 1;
  localparam int SW = 2 * IN_WIDTH;
  localparam int PW = SW + POW_EXTRA;
  localparam int WW = (PW > BIT_WIDTH ? PW : BIT_WIDTH) + 1;
  localparam logic [WW-1:0] MAXV = WW'({BIT_WIDTH{1'b1}});
  logic v1, v2, first, last;
  logic [$clog2(FFT_SIZE)-1:0] b1, b2;
  logic signed [SW-1:0] sq_re, sq_im;
  logic [WW-1:0] pwr;
  logic [BIT_WIDTH-1:0] pw, acc;
  logic [BIT_WIDTH:0] sum;
  assign pwr = WW'({1'b0, sq_re}) + WW'({1'b0, sq_im});
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
    end
    b1 <= bin;
    b2 <= b1;
    sq_re <= SW'(re) * SW'(re);
    sq_im <= SW'(im) * SW'(im);
    pw <= pwr > MAXV ? '1 : pwr[BIT_WIDTH-1:0];
    if (v2) acc <= pool_data;
  end
  // the first bin of a group restarts the sum so stale partials never leak across frames
  always_comb begin
    first = int'(b2) % BINS_PER_OUT == 0;
    last = int'(b2) % BINS_PER_OUT == BINS_PER_OUT - 1;
    sum = {1'b0, acc} + {1'b0, pw};
    pool_data = first ? pw : (sum[BIT_WIDTH] ? '1 : sum[BIT_WIDTH-1:0]);
    pool_valid = v2 && last && int'(b2) / BINS_PER_OUT < I;
    pool_idx = AW'(int'(b2) / BINS_PER_OUT);
  end
endmodule

// File: rtl/fft_power_framer.sv
// fft_power_framer: pools FFT power into ping-pong banks and replays rate-limited bursts
module fft_power_framer #(
  parameter int BIT_WIDTH = formant_pkg::BIT_WIDTH,
  parameter int IN_WIDTH = 16,
  parameter int FFT_SIZE = 1024,
  parameter int I = formant_pkg::I,
  parameter int BINS_PER_OUT = 2,
  parameter int MIN_GAP = 1000000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic fft_in_valid,
  input  logic fft_in_last,
  input  logic signed [IN_WIDTH-1:0] fft_re,
  input  logic signed [IN_WIDTH-1:0] fft_im,
  output logic fft_valid,
  output logic [BIT_WIDTH-1:0] fft_data,
  output logic frame_drop,
  output logic frame_err,
  output logic [15:0] frames_sent
);
  import formant_pkg::*;
  localparam int CW = $clog2(FFT_SIZE);
  localparam int AW = I > 1 ? $clog2(I) : 1;
  localparam int GW = $clog2(MIN_GAP + 2);
  framer_state_t state, state_nx;
  logic [CW-1:0] bin_cnt;
  logic [GW-1:0] gap;
  logic [AW-1:0] rd_addr, pool_idx;
  logic [1:0] drain, sel_d;
  logic wr_sel, rd_sel, at_end, good, err, gap_full, accept, pool_valid;
  logic [BIT_WIDTH-1:0] pool_data;
  logic [BIT_WIDTH-1:0] bank [2][I];
  power_pool #(
    .IN_WIDTH(IN_WIDTH), .BIT_WIDTH(BIT_WIDTH), .FFT_SIZE(FFT_SIZE), .I(I), .BINS_PER_OUT(BINS_PER_OUT)
  ) u_pool (
    .clk(clk_in), .rst(rst_in), .in_valid(fft_in_valid), .bin(bin_cnt), .re(fft_re), .im(fft_im),
    .pool_valid(pool_valid), .pool_idx(pool_idx), .pool_data(pool_data)
  );
  assign at_end = bin_cnt == CW'(FFT_SIZE - 1);
  assign good = fft_in_valid && fft_in_last && at_end;
  assign err = fft_in_valid && (fft_in_last != at_end);
  assign gap_full = gap == GW'(MIN_GAP);
  assign accept = good && gap_full && state == IDLE;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE && accept) ? ARM :
               (state == ARM && drain == 2'd2) ? BURST :
               (state == BURST && rd_addr == AW'(I - 1)) ? IDLE : state;
    fft_valid = state == BURST;
    fft_data = fft_valid ? bank[rd_sel][rd_addr] : '0;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_cnt <= '0;
      gap <= GW'(MIN_GAP);
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      sel_d <= '0;
      rd_addr <= '0;
      drain <= '0;
      frame_drop <= 1'b0;
      frame_err <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (fft_in_valid) bin_cnt <= (fft_in_last || at_end) ? '0 : bin_cnt + CW'(1);
      gap <= accept ? '0 : gap_full ? gap : gap + GW'(1);
      if (accept) begin
        wr_sel <= ~wr_sel;
        rd_sel <= wr_sel;
        frames_sent <= frames_sent + 16'd1;
      end
      // in-flight samples keep writing the bank they were captured for
      sel_d <= {sel_d[0], wr_sel};
      drain <= state == ARM ? drain + 2'd1 : '0;
      rd_addr <= (state == BURST && rd_addr != AW'(I - 1)) ? rd_addr + AW'(1) : '0;
      frame_drop <= good && !accept;
      frame_err <= err;
    end
  end
  always_ff @(posedge clk_in) begin
    if (pool_valid) bank[sel_d[1]][pool_idx] <= pool_data;
  end
endmodule
